// File: rtl/if_id_queue_pkg.sv
// Shared constants for the IF->ID queue slice: RISC-V NOP, major opcodes
// used by predecode, and predecode bit positions.
package if_id_queue_pkg;

  localparam logic [31:0] RV_NOP     = 32'h0000_0013;

  localparam logic [6:0]  OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0]  OPC_JAL    = 7'b110_1111;
  localparam logic [6:0]  OPC_JALR   = 7'b110_0111;
  localparam logic [6:0]  OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0]  OPC_STORE  = 7'b010_0011;

  localparam int unsigned PD_BR   = 3;
  localparam int unsigned PD_JAL  = 2;
  localparam int unsigned PD_JALR = 1;
  localparam int unsigned PD_MEM  = 0;

  typedef logic [3:0] pd_t;

endpackage

// File: rtl/if_id_queue_predecode.sv
// rv_predecode: combinational opcode classifier producing
// {is_branch, is_jal, is_jalr, is_mem} from an instruction word.
module rv_predecode
  import if_id_queue_pkg::*;
#(
  parameter int unsigned ILEN = 32
) (
  input  logic [ILEN-1:0] i_instr,
  output pd_t             o_pd
);

  logic [6:0] w_opc;
  logic       w_unused_bits;

  assign w_opc         = i_instr[6:0];
  assign w_unused_bits = ^i_instr[ILEN-1:7];

  // Classify the major opcode into one-hot predecode flags.
  always_comb begin
    o_pd = '0;
    case (w_opc)
      OPC_BRANCH: o_pd[PD_BR]   = 1'b1;
      OPC_JAL:    o_pd[PD_JAL]  = 1'b1;
      OPC_JALR:   o_pd[PD_JALR] = 1'b1;
      OPC_LOAD,
      OPC_STORE:  o_pd[PD_MEM]  = 1'b1;
      default:    o_pd = '0;
    endcase
  end

endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry elastic IF->ID boundary with valid/ready on both
// sides and a synchronous flush. Carries PC, instruction and fetch fault.
// Build option IFQ_PREDECODE_EN: predecode vector computed at push time and
// stored per entry; otherwise out_predecode is tied to zero.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ILEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [ILEN-1:0]            in_instr,
  input  logic                       in_fault,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [ILEN-1:0]            out_instr,
  output logic                       out_fault,
  output logic [3:0]                 out_predecode,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] r_pc    [DEPTH];
  logic [ILEN-1:0] r_instr [DEPTH];
  logic            r_fault [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic w_push;
  logic w_pop;

  // Handshake flags depend on registered occupancy only.
  assign in_ready  = (r_count != CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign count     = r_count;

  // Entry storage; not reset, a write without pointer advance is harmless.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[r_wr_ptr]    <= in_pc;
      r_instr[r_wr_ptr] <= in_instr;
      r_fault[r_wr_ptr] <= in_fault;
    end
  end

  // Pointers and occupancy; reset and flush dominate any push or pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head mux; an empty queue presents a NOP so stale storage stays hidden.
  always_comb begin
    out_pc    = '0;
    out_instr = ILEN'(RV_NOP);
    out_fault = 1'b0;
    if (out_valid) begin
      out_pc    = r_pc[r_rd_ptr];
      out_instr = r_instr[r_rd_ptr];
      out_fault = r_fault[r_rd_ptr];
    end
  end

`ifdef IFQ_PREDECODE_EN
  pd_t w_pd;
  pd_t r_pd [DEPTH];

  rv_predecode #(.ILEN(ILEN)) u_predecode (
    .i_instr (in_instr),
    .o_pd    (w_pd)
  );

  // Predecode is masked for faulted entries at push time.
  always_ff @(posedge clk) begin
    if (w_push) r_pd[r_wr_ptr] <= in_fault ? '0 : w_pd;
  end

  // Read side is a plain mux of stored bits.
  always_comb begin
    out_predecode = '0;
    if (out_valid) out_predecode = r_pd[r_rd_ptr];
  end
`else
  assign out_predecode = 4'b0000;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: two instances (DEPTH=2 and DEPTH=4) share stimulus;
// each is compared every cycle against a queue-based model.
module tb_if_id_queue;

`ifdef IFQ_PREDECODE_EN
  localparam bit PD_ON = 1'b1;
`else
  localparam bit PD_ON = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, in_fault, out_ready;
  logic [31:0] in_pc, in_instr;

  logic        a_in_ready, a_out_valid, a_out_fault;
  logic [31:0] a_out_pc, a_out_instr;
  logic [3:0]  a_out_pd;
  logic [1:0]  a_count;

  logic        b_in_ready, b_out_valid, b_out_fault;
  logic [31:0] b_out_pc, b_out_instr;
  logic [3:0]  b_out_pd;
  logic [2:0]  b_count;

  if_id_queue #(.XLEN(32), .ILEN(32), .DEPTH(2)) u_dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_fault(in_fault),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_out_pc), .out_instr(a_out_instr), .out_fault(a_out_fault),
    .out_predecode(a_out_pd), .count(a_count)
  );

  if_id_queue #(.XLEN(32), .ILEN(32), .DEPTH(4)) u_dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_fault(in_fault),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_out_pc), .out_instr(b_out_instr), .out_fault(b_out_fault),
    .out_predecode(b_out_pd), .count(b_count)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];
  int   total = 0;
  int   bad   = 0;
  int   max_b = 0;

  function automatic logic [3:0] exp_pd(input logic [31:0] ins, input logic f);
    logic [3:0] pd;
    logic [6:0] opc;
    opc = ins[6:0];
    case (opc)
      7'h63:        pd = 4'b1000;
      7'h6F:        pd = 4'b0100;
      7'h67:        pd = 4'b0010;
      7'h03, 7'h23: pd = 4'b0001;
      default:      pd = 4'b0000;
    endcase
    if (f || !PD_ON) pd = 4'b0000;
    return pd;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare both instances against the model state.
  task automatic check_all();
    ent_t h;
    if (qa.size() != 0) begin
      h = qa[0];
      cmp("a.out_valid", a_out_valid, 1);
      cmp("a.out_pc", a_out_pc, h.pc);
      cmp("a.out_instr", a_out_instr, h.instr);
      cmp("a.out_fault", a_out_fault, h.fault);
      cmp("a.out_pd", a_out_pd, exp_pd(h.instr, h.fault));
    end else begin
      cmp("a.out_valid", a_out_valid, 0);
      cmp("a.out_pc", a_out_pc, 0);
      cmp("a.out_instr", a_out_instr, NOP);
      cmp("a.out_fault", a_out_fault, 0);
      cmp("a.out_pd", a_out_pd, 0);
    end
    cmp("a.in_ready", a_in_ready, qa.size() != 2);
    cmp("a.count", a_count, qa.size());
    if (qb.size() != 0) begin
      h = qb[0];
      cmp("b.out_valid", b_out_valid, 1);
      cmp("b.out_pc", b_out_pc, h.pc);
      cmp("b.out_instr", b_out_instr, h.instr);
      cmp("b.out_fault", b_out_fault, h.fault);
      cmp("b.out_pd", b_out_pd, exp_pd(h.instr, h.fault));
    end else begin
      cmp("b.out_valid", b_out_valid, 0);
      cmp("b.out_pc", b_out_pc, 0);
      cmp("b.out_instr", b_out_instr, NOP);
      cmp("b.out_fault", b_out_fault, 0);
      cmp("b.out_pd", b_out_pd, 0);
    end
    cmp("b.in_ready", b_in_ready, qb.size() != 4);
    cmp("b.count", b_count, qb.size());
    if (int'(b_count) > max_b) max_b = int'(b_count);
  endtask

  // Drive one cycle, advance the model, then check after the edge.
  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [31:0] pc, input logic [31:0] ins,
                      input logic flt, input logic ordy);
    ent_t e;
    bit   pu, po;
    rst = r; flush = f; in_valid = iv; in_pc = pc; in_instr = ins;
    in_fault = flt; out_ready = ordy;
    e.pc = pc; e.instr = ins; e.fault = flt;
    if (r || f) begin
      qa.delete();
      qb.delete();
    end else begin
      po = (qa.size() != 0) && ordy;
      pu = iv && (qa.size() != 2);
      if (po) qa.delete(0);
      if (pu) qa.push_back(e);
      po = (qb.size() != 0) && ordy;
      pu = iv && (qb.size() != 4);
      if (po) qb.delete(0);
      if (pu) qb.push_back(e);
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    logic [31:0] rpc, rins;
    logic [6:0]  opc;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
    in_fault = 1'b0; out_ready = 1'b0;

    // Reset held two cycles.
    step(1, 0, 0, 32'h0, 32'h0, 0, 0);
    step(1, 0, 0, 32'h0, 32'h0, 0, 0);
    cmp("rst.out_valid", a_out_valid, 0);
    cmp("rst.in_ready", a_in_ready, 1);
    cmp("rst.count", a_count, 0);
    cmp("rst.out_instr", a_out_instr, 32'h0000_0013);
    step(0, 0, 0, 32'h0, 32'h0, 0, 0);

    // Fill DEPTH=2 instance, third push refused and held.
    step(0, 0, 1, 32'h00, 32'h0000_0033, 0, 0);
    step(0, 0, 1, 32'h04, 32'h0000_0033, 0, 0);
    cmp("fill.count", a_count, 2);
    cmp("fill.in_ready", a_in_ready, 0);
    step(0, 0, 1, 32'h08, 32'h0000_0033, 0, 0);
    cmp("fill.refused_count", a_count, 2);
    cmp("fill.head_pc", a_out_pc, 32'h00);
    step(0, 0, 1, 32'h08, 32'h0000_0033, 0, 1);
    cmp("fill.pop_full_count", a_count, 1);
    step(0, 0, 1, 32'h08, 32'h0000_0033, 0, 0);
    cmp("fill.accept_count", a_count, 2);

    // Flush collides with a push of 0x40 while full.
    step(0, 1, 1, 32'h40, 32'h0000_0033, 0, 0);
    cmp("flush.count", a_count, 0);
    cmp("flush.out_valid", a_out_valid, 0);
    cmp("flush.in_ready", a_in_ready, 1);

    // Streaming: 8 PCs with push and pop every cycle.
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 1, 32'(k * 4), 32'h0000_0013, 0, 1);
      cmp("stream.count", a_count, 1);
      cmp("stream.pc", a_out_pc, 32'(k * 4));
    end
    step(0, 0, 0, 32'h0, 32'h0, 0, 1);
    step(0, 0, 0, 32'h0, 32'h0, 0, 1);
    cmp("stream.drained", a_out_valid, 0);

    // Predecode on a few known encodings.
    step(0, 1, 0, 32'h0, 32'h0, 0, 0);
    step(0, 0, 1, 32'h100, 32'h0000_006F, 0, 0);
    cmp("pd.jal", a_out_pd, PD_ON ? 4'b0100 : 4'b0000);
    step(0, 0, 1, 32'h104, 32'h0082_2823, 0, 1);
    cmp("pd.sw", a_out_pd, PD_ON ? 4'b0001 : 4'b0000);
    step(0, 0, 1, 32'h108, 32'h0000_006F, 1, 1);
    cmp("pd.jal_fault", a_out_pd, 4'b0000);
    cmp("pd.fault_bit", a_out_fault, 1);

    // Randomised traffic with occasional flush and reset.
    for (int n = 0; n < 500; n++) begin
      rpc  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      rins = $urandom;
      case ($urandom_range(0, 6))
        0: opc = 7'h63;
        1: opc = 7'h6F;
        2: opc = 7'h67;
        3: opc = 7'h03;
        4: opc = 7'h23;
        default: opc = 7'h13;
      endcase
      rins[6:0] = opc;
      step($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) != 0, rpc, rins,
           $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
    end
    cmp("wrap.max_count_le_4", max_b <= 4, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
